// File: rtl/icache_dm.sv
// Direct-mapped ASID-tagged I-cache; hit answers the cycle after the request, a miss refills a whole line first.
// Backpressure: fe1_stall holds a hit response in place; ic_busy stalls fetch1 while a miss or refill is pending.
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        fe0_read_req,
  input  logic [8:0]  fe0_read_asid,
  input  logic [29:0] fe0_read_addr,
  input  logic        fe1_stall,
  input  logic        csr_kill,
  input  logic        ic_invalidate,
  output logic        ic_valid,
  output logic [29:0] ic_addr,
  output logic [31:0] ic_data,
  output logic        ic_busy,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t            state;
  logic              s_vld;
  logic [29:0]       s_addr;
  logic [8:0]        s_asid;
  logic [LINES-1:0]  line_vld;
  logic [TW-1:0]     tag_mem  [LINES];
  logic [8:0]        asid_mem [LINES];
  logic [31:0]       data_mem [LINES*WORDS];
  logic [OW-1:0]     beat;
  logic              inv_pend;
  logic [8:0]        fill_asid;

  logic [IW-1:0]     s_idx;
  logic [TW-1:0]     s_tag;
  logic [IW-1:0]     fill_idx;
  logic [TW-1:0]     fill_tag;
  logic              hit;
  logic              last_beat;

  assign s_idx    = s_addr[OW+IW-1:OW];
  assign s_tag    = s_addr[29:OW+IW];
  assign fill_idx = mem_addr[OW+IW-1:OW];
  assign fill_tag = mem_addr[29:OW+IW];

  assign hit = s_vld && line_vld[s_idx] && (tag_mem[s_idx] == s_tag)
               && (asid_mem[s_idx] == s_asid);
  assign last_beat = (state == DATA) && mem_rvalid && (beat == OW'(WORDS - 1));

  assign ic_valid = (state == IDLE) && hit;
  assign ic_busy  = (state != IDLE) || (s_vld && !hit);
  assign ic_addr  = s_addr;
  assign ic_data  = data_mem[{s_idx, s_addr[OW-1:0]}];

  always_ff @(posedge clk_core) begin
    if (reset) begin
      state     <= IDLE;
      s_vld     <= 1'b0;
      s_addr    <= '0;
      s_asid    <= '0;
      line_vld  <= '0;
      beat      <= '0;
      inv_pend  <= 1'b0;
      fill_asid <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      // A new request wins over a kill; a consumed hit frees the hold register.
      if (fe0_read_req) begin
        s_vld  <= 1'b1;
        s_addr <= fe0_read_addr;
        s_asid <= fe0_read_asid;
      end else if (csr_kill) begin
        s_vld <= 1'b0;
      end else if (state == IDLE && hit && !fe1_stall) begin
        s_vld <= 1'b0;
      end

      if (ic_invalidate && state != IDLE)
        inv_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (s_vld && !hit) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= {s_addr[29:OW], {OW{1'b0}}};
            fill_asid <= s_asid;
            inv_pend  <= 1'b0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (mem_rvalid) begin
            beat <= beat + OW'(1);
            if (last_beat) begin
              // An invalidate seen at any point of this fill keeps the line invalid.
              line_vld[fill_idx] <= !(inv_pend || ic_invalidate);
              inv_pend           <= 1'b0;
              state              <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (ic_invalidate)
        line_vld <= '0;
    end
  end

  // Data, tag and ASID arrays carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk_core) begin
    if (!reset && state == DATA && mem_rvalid) begin
      data_mem[{fill_idx, beat}] <= mem_rdata;
      if (last_beat) begin
        tag_mem[fill_idx]  <= fill_tag;
        asid_mem[fill_idx] <= fill_asid;
      end
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: drives fetch/memory sides with a scripted burst responder.
module tb_icache_dm;

  logic        clk_core = 1'b0;
  logic        reset = 1'b1;
  logic        fe0_read_req = 1'b0;
  logic [8:0]  fe0_read_asid = '0;
  logic [29:0] fe0_read_addr = '0;
  logic        fe1_stall = 1'b0;
  logic        csr_kill = 1'b0;
  logic        ic_invalidate = 1'b0;
  logic        ic_valid;
  logic [29:0] ic_addr;
  logic [31:0] ic_data;
  logic        ic_busy;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_pass = 0;

  icache_dm #(.LINES(16), .WORDS(4)) dut (
    .clk_core(clk_core), .reset(reset),
    .fe0_read_req(fe0_read_req), .fe0_read_asid(fe0_read_asid), .fe0_read_addr(fe0_read_addr),
    .fe1_stall(fe1_stall), .csr_kill(csr_kill), .ic_invalidate(ic_invalidate),
    .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_data(ic_data), .ic_busy(ic_busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  // Memory image: word address 0x100 holds 0xA0, each following address one more.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return 32'hA0 + {2'b00, a} - 32'h100;
  endfunction

  task automatic issue(input logic [29:0] a, input logic [8:0] asid);
    fe0_read_req  = 1'b1;
    fe0_read_addr = a;
    fe0_read_asid = asid;
    step();
    fe0_read_req  = 1'b0;
  endtask

  // Waits for mem_req, acks after ack_dly cycles and returns nbeats beats.
  // ev_beat selects a beat during which a redirect or kill is driven.
  task automatic serve_fill(input logic [29:0] line, input int ack_dly, input int nbeats,
                            input int ev_beat, input logic ev_req, input logic [29:0] ev_addr,
                            input logic ev_kill, input logic inv_req);
    int w = 0;
    while (!mem_req && w < 8) begin
      step();
      w++;
    end
    check("mem_req_rise", {31'b0, mem_req}, 32'd1);
    check("mem_addr", {2'b0, mem_addr}, {2'b0, line});
    for (int d = 0; d < ack_dly; d++) begin
      check("mem_req_hold", {31'b0, mem_req}, 32'd1);
      check("mem_addr_hold", {2'b0, mem_addr}, {2'b0, line});
      if (d == 0 && inv_req) ic_invalidate = 1'b1;
      step();
      ic_invalidate = 1'b0;
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("mem_req_drop", {31'b0, mem_req}, 32'd0);
    check("busy_in_data", {31'b0, ic_busy}, 32'd1);
    for (int i = 0; i < nbeats; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(line + 30'(i));
      if (i == ev_beat) begin
        csr_kill = ev_kill;
        if (ev_req) begin
          fe0_read_req  = 1'b1;
          fe0_read_addr = ev_addr;
          fe0_read_asid = 9'd3;
        end
      end
      step();
      mem_rvalid   = 1'b0;
      csr_kill     = 1'b0;
      fe0_read_req = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    check("rst_valid", {31'b0, ic_valid}, 32'd0);
    check("rst_busy", {31'b0, ic_busy}, 32'd0);
    check("rst_addr", {2'b0, ic_addr}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_addr", {2'b0, mem_addr}, 32'd0);
    reset = 1'b0;
    step();

    // Cold miss on 0x100 asid 3, ack after two cycles.
    issue(30'h100, 9'd3);
    check("cold_busy", {31'b0, ic_busy}, 32'd1);
    check("cold_valid", {31'b0, ic_valid}, 32'd0);
    check("cold_noreq_n1", {31'b0, mem_req}, 32'd0);
    step();
    serve_fill(30'h100, 2, 4, -1, 1'b0, '0, 1'b0, 1'b0);
    check("cold_rsp_valid", {31'b0, ic_valid}, 32'd1);
    check("cold_rsp_data", ic_data, 32'hA0);
    check("cold_rsp_addr", {2'b0, ic_addr}, 32'h100);
    check("cold_rsp_busy", {31'b0, ic_busy}, 32'd0);

    // Back-to-back hits.
    fe0_read_req = 1'b1;
    fe0_read_asid = 9'd3;
    for (int i = 1; i < 4; i++) begin
      fe0_read_addr = 30'h100 + 30'(i);
      step();
      check("hit_valid", {31'b0, ic_valid}, 32'd1);
      check("hit_data", ic_data, 32'hA0 + 32'(i));
      check("hit_no_mem_req", {31'b0, mem_req}, 32'd0);
    end
    fe0_read_req = 1'b0;
    step();
    check("hit_consumed", {31'b0, ic_valid}, 32'd0);
    check("hit_idle_busy", {31'b0, ic_busy}, 32'd0);

    // ASID mismatch refills the line for asid 4, then asid 3 misses again.
    issue(30'h101, 9'd4);
    check("asid4_miss", {31'b0, ic_busy}, 32'd1);
    serve_fill(30'h100, 0, 4, -1, 1'b0, '0, 1'b0, 1'b0);
    check("asid4_valid", {31'b0, ic_valid}, 32'd1);
    check("asid4_data", ic_data, 32'hA1);
    step();
    issue(30'h101, 9'd3);
    check("asid3_remiss", {31'b0, ic_busy}, 32'd1);
    check("asid3_remiss_valid", {31'b0, ic_valid}, 32'd0);
    serve_fill(30'h100, 0, 4, -1, 1'b0, '0, 1'b0, 1'b0);
    check("asid3_valid", {31'b0, ic_valid}, 32'd1);
    step();

    // Stalled hit holds for three cycles, consumed once released.
    fe1_stall = 1'b1;
    issue(30'h102, 9'd3);
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", {31'b0, ic_valid}, 32'd1);
      check("stall_addr", {2'b0, ic_addr}, 32'h102);
      check("stall_data", ic_data, 32'hA2);
      step();
    end
    fe1_stall = 1'b0;
    check("stall_release_valid", {31'b0, ic_valid}, 32'd1);
    step();
    check("stall_consumed", {31'b0, ic_valid}, 32'd0);

    // Invalidate in IDLE, then redirect to 0x200 during the refill of 0x100.
    ic_invalidate = 1'b1;
    step();
    ic_invalidate = 1'b0;
    issue(30'h100, 9'd3);
    check("inv_idle_miss", {31'b0, ic_busy}, 32'd1);
    serve_fill(30'h100, 1, 4, 1, 1'b1, 30'h200, 1'b0, 1'b0);
    check("redir_miss_valid", {31'b0, ic_valid}, 32'd0);
    check("redir_miss_busy", {31'b0, ic_busy}, 32'd1);
    check("redir_addr", {2'b0, ic_addr}, 32'h200);
    serve_fill(30'h200, 0, 4, -1, 1'b0, '0, 1'b0, 1'b0);
    check("redir_valid", {31'b0, ic_valid}, 32'd1);
    check("redir_data", ic_data, 32'h1A0);
    step();

    // Kill alone during DATA: refill completes, nothing returned.
    issue(30'h100, 9'd3);
    serve_fill(30'h100, 0, 4, 2, 1'b0, '0, 1'b1, 1'b0);
    check("kill_valid", {31'b0, ic_valid}, 32'd0);
    check("kill_busy", {31'b0, ic_busy}, 32'd0);
    issue(30'h100, 9'd3);
    check("kill_line_filled", {31'b0, ic_valid}, 32'd1);
    check("kill_line_data", ic_data, 32'hA0);
    step();

    // Invalidate during REQ suppresses the fill; the line is fetched again.
    issue(30'h104, 9'd3);
    serve_fill(30'h104, 2, 4, -1, 1'b0, '0, 1'b0, 1'b1);
    check("invreq_valid", {31'b0, ic_valid}, 32'd0);
    check("invreq_busy", {31'b0, ic_busy}, 32'd1);
    serve_fill(30'h104, 0, 4, -1, 1'b0, '0, 1'b0, 1'b0);
    check("invreq_refetch_valid", {31'b0, ic_valid}, 32'd1);
    check("invreq_refetch_data", ic_data, 32'hA4);
    step();

    // Reset in the middle of DATA.
    issue(30'h108, 9'd3);
    serve_fill(30'h108, 0, 2, -1, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mid_busy", {31'b0, ic_busy}, 32'd0);
    for (int i = 2; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD0000 + 32'(i);
      step();
      mem_rvalid = 1'b0;
    end
    check("rst_late_beats_req", {31'b0, mem_req}, 32'd0);
    check("rst_late_beats_valid", {31'b0, ic_valid}, 32'd0);
    issue(30'h108, 9'd3);
    check("rst_line_miss", {31'b0, ic_busy}, 32'd1);
    check("rst_line_miss_valid", {31'b0, ic_valid}, 32'd0);
    serve_fill(30'h108, 1, 4, -1, 1'b0, '0, 1'b0, 1'b0);
    check("rst_refill_valid", {31'b0, ic_valid}, 32'd1);
    check("rst_refill_data", ic_data, 32'hA8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
